noc_pe_endpoint: RTL
====================

Name: noc_pe_endpoint

Overview:
- PE-side endpoint for the BFT NoC port.
- TX path packetizes a request (destination plus burst length) and a payload word stream into flits {addr, data}. It drives them onto the NoC ingress port (peo) with valid/ready/last.
- RX path drains the NoC egress port (pei) into a local FIFO, checks the destination address against its own PE index, and presents flits to the PE.
- One instance sits beside each PE, outside the network top.

Parameters:
- N, 4: number of PEs on the network.
- D_W, 32: payload data width.
- A_W, $clog2(N)+1: flit address field width.
- SELF, 0: this endpoint's PE index (0..N-1).
- LEN_W, 8: burst length field width; lengths 1..2^LEN_W-1.
- RX_DEPTH, 4: RX FIFO depth, power of two, minimum 2.
- CNT_W, 16: packet counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  TX request valid.
- req_ready  out  1  TX request accepted.
- req_dest  in  A_W  destination PE address.
- req_len  in  LEN_W  payload words in the packet.
- tx_data  in  D_W  payload word.
- tx_valid  in  1  payload word valid.
- tx_ready  out  1  payload word accepted.
- peo_data  out  A_W+D_W  flit to NoC, {addr, data}.
- peo_v  out  1  flit valid.
- peo_l  out  1  last flit of packet.
- peo_r  in  1  NoC ready.
- pei_data  in  A_W+D_W  flit from NoC.
- pei_v  in  1  flit valid.
- pei_l  in  1  last flit.
- pei_r  out  1  endpoint ready.
- rx_data  out  D_W  received payload.
- rx_addr  out  A_W  received flit address.
- rx_last  out  1  received last flag.
- rx_valid  out  1  RX output valid.
- rx_ready  in  1  PE accepts RX word.
- tx_pkt_cnt  out  CNT_W  completed TX packets, wraps.
- rx_pkt_cnt  out  CNT_W  completed RX packets, wraps.
- rx_misroute  out  1  sticky address-mismatch flag.

Behaviour:

Reset (asynchronous, active-high):
- All outputs go to 0.
- FSM returns to IDLE; FIFO pointers and counters clear; rx_misroute clears.
- Reset mid-packet discards the partial packet. No flit is emitted after reset until a new request is accepted.

Handshake rule:
- A transfer occurs on any edge where valid & ready are both high.
- Valid never depends combinationally on ready.
- data and last are held stable while valid is high and ready is low.

TX FSM, states IDLE and SEND:
- IDLE: req_ready=1, tx_ready=0.
  - Request with req_len==0 is accepted and dropped: no flit, no count.
  - Any other accepted request latches dest and remaining=req_len, then moves to SEND.
- SEND: req_ready=0.
  - tx_ready = !peo_v | peo_r (single output register, full-throughput pipelining).
  - Each accepted payload word loads the output register with peo_data={dest, tx_data}, peo_v=1, and peo_l=(remaining==1). remaining then decrements.
  - On the edge where the word with remaining==1 is accepted, the FSM returns to IDLE.
- The output register drains independently. peo_v falls once its flit transfers and no new word loads on that edge.
- tx_pkt_cnt increments when a flit with peo_l=1 transfers on peo.
- Latency: payload word accepted at edge k gives peo_v=1 from cycle k+1.
- Back-to-back packets: a new request may be accepted in IDLE while the last flit still sits in the output register.
- req_dest==SELF is legal and is sent unchanged.

RX path:
- FIFO of RX_DEPTH entries, each {last, addr, data}.
- pei_r = !full, registered-output style: computed from pointers, no combinational path from pei_v.
- Write on pei_v & pei_r. Read on rx_valid & rx_ready. rx_valid = !empty, first-word-fall-through.
- Simultaneous read and write when full: the read frees space next cycle only; pei_r stays low that cycle.
- Simultaneous read and write when empty: the write is visible at the output next cycle.
- rx_pkt_cnt increments on a write with last=1.
- rx_misroute: set when a written flit has addr[A_W-2:0] != SELF; stays set until reset. The flit is still stored and delivered.
- Pointer wrap: pointers are $clog2(RX_DEPTH)+1 bits; full and empty are decoded from the MSB difference.
- Counters wrap from 2^CNT_W-1 to 0.

Decomposition:
- Package noc_ep_pkg holds:
  - flit width function FLIT_W(A_W,D_W)=A_W+D_W;
  - TX FSM state encoding, IDLE=0 and SEND=1;
  - field slice helpers addr_of() and data_of().
- One sub-module, noc_ep_fifo: synchronous FIFO parameterized by width and depth, with full/empty outputs, asynchronous reset, and first-word-fall-through read. Used by the RX path.

Test Plan (N=4, D_W=32, A_W=3, SELF=1):
- Single-flit packet: req dest=2, len=1; tx_data=0xDEADBEEF; peo_r=1 -> exactly one flit peo_data={3'd2,0xDEADBEEF} with peo_l=1, one cycle after acceptance; tx_pkt_cnt=1.
- Burst under backpressure: len=4, words 0..3; peo_r toggles 1,0,0,1,... -> four flits in order, no duplicates or drops; peo_l=1 only on word 3; data held stable while stalled.
- len=0 request -> req_ready pulses; no peo_v; tx_pkt_cnt unchanged; the next request (len=2) is sent correctly.
- RX fill: inject 5 flits addressed 3'd1, rx_ready=0 -> pei_r drops after the 4th write. Then rx_ready=1 -> words delivered in order; rx_pkt_cnt counts last flags; rx_misroute stays 0.
- Misroute: inject flit addr=3'd2 -> flit delivered, rx_misroute=1 and remains 1 until rst.
- Reset mid-burst: assert rst after 2 of 4 flits -> peo_v=0 and counters 0 immediately (asynchronous). After release, a new len=1 request sends one flit with peo_l=1.

Source files
------------

// File: rtl/noc_ep_pkg.sv
// Shared types and flit field helpers for the PE-side NoC endpoint.
package noc_ep_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    function automatic int FLIT_W(input int a_w, input int d_w);
        return a_w + d_w;
    endfunction

    // Helpers work on a zero-extended flit; callers cast the result to field width.
    function automatic logic [MAX_W-1:0] addr_of(input logic [MAX_W-1:0] flit, input int d_w);
        return flit >> d_w;
    endfunction

    function automatic logic [MAX_W-1:0] data_of(input logic [MAX_W-1:0] flit, input int d_w);
        return flit & ~({MAX_W{1'b1}} << d_w);
    endfunction

endpackage

// File: rtl/noc_ep_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty decoded from wrap-bit pointers.
// Write at full is ignored; a read at full frees its slot only from the next cycle.
module noc_ep_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  mem_q [DEPTH];

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en && !full) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en && !empty) rd_ptr_d = rd_ptr_q + PW'(1);
        rd_dat   = mem_q[rd_ptr_q[PW-2:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (wr_en && !full) mem_q[wr_ptr_q[PW-2:0]] <= wr_dat;
        end
    end

endmodule

// File: rtl/noc_pe_endpoint.sv
// PE-side NoC endpoint: TX packetizer into a single output register, RX FIFO with address check.
// TX flit appears one cycle after payload acceptance; RX word visible one cycle after write.
module noc_pe_endpoint
    import noc_ep_pkg::*;
#(
    parameter int N        = 4,
    parameter int D_W      = 32,
    parameter int A_W      = $clog2(N) + 1,
    parameter int SELF     = 0,
    parameter int LEN_W    = 8,
    parameter int RX_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [A_W-1:0]       req_dest,
    input  logic [LEN_W-1:0]     req_len,
    input  logic [D_W-1:0]       tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [A_W+D_W-1:0]   peo_data,
    output logic                 peo_v,
    output logic                 peo_l,
    input  logic                 peo_r,
    input  logic [A_W+D_W-1:0]   pei_data,
    input  logic                 pei_v,
    input  logic                 pei_l,
    output logic                 pei_r,
    output logic [D_W-1:0]       rx_data,
    output logic [A_W-1:0]       rx_addr,
    output logic                 rx_last,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [CNT_W-1:0]     tx_pkt_cnt,
    output logic [CNT_W-1:0]     rx_pkt_cnt,
    output logic                 rx_misroute
);
    localparam int FW = FLIT_W(A_W, D_W);
    localparam int SELF_MOD = SELF % N;
    localparam logic [A_W-2:0] SELF_LO = (A_W-1)'(SELF_MOD);

    tx_state_e        state_q, state_d;
    logic [A_W-1:0]   dest_q, dest_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [FW-1:0]    peo_data_q, peo_data_d;
    logic             peo_v_q, peo_v_d;
    logic             peo_l_q, peo_l_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic             mis_q, mis_d;

    logic             fifo_full, fifo_empty, wr_en, rd_en;
    logic [FW:0]      rd_dat;
    logic [A_W-1:0]   pei_addr;

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        rem_d      = rem_q;
        peo_data_d = peo_data_q;
        peo_v_d    = peo_v_q;
        peo_l_d    = peo_l_q;
        tx_cnt_d   = tx_cnt_q;
        req_ready  = 1'b0;
        tx_ready   = 1'b0;

        // Output register drains on its own; a load on the same edge overrides below.
        if (peo_v_q && peo_r) begin
            peo_v_d = 1'b0;
            if (peo_l_q) tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst && (req_len != '0)) begin
                    dest_d  = req_dest;
                    rem_d   = req_len;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_ready = !peo_v_q || peo_r;
                if (tx_valid && tx_ready) begin
                    peo_data_d = {dest_q, tx_data};
                    peo_v_d    = 1'b1;
                    peo_l_d    = (rem_q == LEN_W'(1));
                    rem_d      = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pei_r    = !fifo_full && !rst;
        wr_en    = pei_v && pei_r;
        rd_en    = rx_valid && rx_ready;
        pei_addr = A_W'(addr_of(MAX_W'(pei_data), D_W));
        rx_cnt_d = rx_cnt_q;
        mis_d    = mis_q;
        if (wr_en && pei_l) rx_cnt_d = rx_cnt_q + CNT_W'(1);
        if (wr_en && (pei_addr[A_W-2:0] != SELF_LO)) mis_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dest_q     <= '0;
            rem_q      <= '0;
            peo_data_q <= '0;
            peo_v_q    <= 1'b0;
            peo_l_q    <= 1'b0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            rem_q      <= rem_d;
            peo_data_q <= peo_data_d;
            peo_v_q    <= peo_v_d;
            peo_l_q    <= peo_l_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            mis_q      <= mis_d;
        end
    end

    noc_ep_fifo #(
        .W     (FW + 1),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_dat ({pei_l, pei_data}),
        .rd_en  (rd_en),
        .rd_dat (rd_dat),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign peo_data    = peo_data_q;
    assign peo_v       = peo_v_q;
    assign peo_l       = peo_l_q;
    assign tx_pkt_cnt  = tx_cnt_q;
    assign rx_pkt_cnt  = rx_cnt_q;
    assign rx_misroute = mis_q;
    assign rx_valid    = !fifo_empty;
    assign rx_last     = rd_dat[FW];
    assign rx_addr     = A_W'(addr_of(MAX_W'(rd_dat[FW-1:0]), D_W));
    assign rx_data     = D_W'(data_of(MAX_W'(rd_dat[FW-1:0]), D_W));

endmodule
